// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard sources and memory status in,
// pipeline register enables and controller status out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_exe_bubble;
  logic             id_exe_hold;
  logic             ex_mem_hold;
  logic             error;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_exe_bubble, id_exe_hold,
           ex_mem_hold, error, state, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_exe_bubble, id_exe_hold,
           ex_mem_hold, error, state, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes, data-memory freeze with timeout, stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  state_t           state, state_n, ret, ret_n;
  logic [7:0]       flush_cnt, flush_n, wait_cnt, wait_n;
  logic             error, error_n;
  logic [CNT_W-1:0] stall_cnt;

  logic busy, load_use, freeze, flush, lstall;
  logic pc_write, if_id_write, if_id_flush, bubble, hold;

  always_comb begin
    // Once the timeout has fired the memory is treated as ready, so the
    // pipeline stays released until reset.
    busy     = hz.mem_busy && !error;
    load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
               ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    freeze  = 1'b0;
    flush   = 1'b0;
    lstall  = 1'b0;
    state_n = state;
    ret_n   = ret;
    flush_n = flush_cnt;
    wait_n  = wait_cnt;
    error_n = error;

    case (state)
      RUN, LOAD_STALL: begin
        if (busy) begin
          freeze  = 1'b1;
          wait_n  = 8'd1;
          ret_n   = RUN;
          state_n = MEM_WAIT;
        end else if ((state == RUN) && hz.branch_taken) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            flush_n = 8'(FLUSH_CYCLES - 1);
          end else begin
            state_n = RUN;
          end
        end else if ((state == RUN) && load_use) begin
          lstall  = 1'b1;
          state_n = LOAD_STALL;
        end else begin
          state_n = RUN;
        end
      end
      FLUSH: begin
        if (busy) begin
          freeze  = 1'b1;
          wait_n  = 8'd1;
          ret_n   = FLUSH;
          state_n = MEM_WAIT;
        end else begin
          flush = 1'b1;
          if (flush_cnt <= 8'd1) begin
            flush_n = '0;
            state_n = RUN;
          end else begin
            flush_n = flush_cnt - 8'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (!busy) begin
          state_n = ret;
        end else begin
          freeze = 1'b1;
          wait_n = wait_cnt + 8'd1;
          // wait_cnt counts busy cycles including the entry cycle.
          if (wait_n >= 8'(MAX_WAIT)) begin
            error_n = 1'b1;
            state_n = RUN;
          end
        end
      end
      default: state_n = RUN;
    endcase

    pc_write    = !(freeze || lstall);
    if_id_write = !(freeze || lstall);
    if_id_flush = flush;
    bubble      = flush || lstall;
    hold        = freeze;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      bubble      = 1'b1;
      hold        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret       <= RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      error     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      ret       <= ret_n;
      flush_cnt <= flush_n;
      wait_cnt  <= wait_n;
      error     <= error_n;
      if ((!pc_write || bubble) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_exe_bubble = bubble;
  assign hz.id_exe_hold   = hold;
  assign hz.ex_mem_hold   = hold;
  assign hz.error         = error;
  assign hz.state         = state;
  assign hz.stall_count   = stall_cnt;

endmodule
